life_engine: RTL and testbench
==============================

Name: life_engine

Overview:
Parametrised Game-of-Life grid engine, successor to the fixed 8x8 CONTROL block. Holds a ROWS x COLS cell grid and evolves it one generation per enabled cycle. Adds run/step/halt control, programmable birth/survive rules, toroidal or dead-edge boundaries, a generation counter and stable/extinct detection. Feeds the display/readout path with the flat grid vector.

Parameters:
ROWS, 8, grid rows (>=3)
COLS, 8, grid columns (>=3)
WRAP, 1, 1 = toroidal edges; 0 = out-of-bounds neighbours are dead
GEN_W, 16, generation counter width

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
load  in  1  load seed into grid (level, sampled each cycle)
seed  in  ROWS*COLS  initial pattern; cell (r,c) = bit r*COLS+c
run  in  1  free-run enable (level)
step  in  1  single-generation request (one-cycle pulse)
stop_on_stable  in  1  auto-halt when next grid equals current grid
birth_mask  in  9  bit n set: dead cell with n live neighbours is born (Conway = 9'b000001000)
survive_mask  in  9  bit n set: live cell with n neighbours survives (Conway = 9'b000001100)
grid  out  ROWS*COLS  current grid; row 0 = grid[COLS-1:0]
generation  out  GEN_W  generations evolved since last load/reset
stable  out  1  last evaluation found next == grid
extinct  out  1  last evolve produced an all-zero grid
halted  out  1  FSM in HALT

Behaviour:
- Reset (reset=0, async): grid=0, generation=0, stable=0, extinct=0, halted=0, state IDLE.
- next_grid is combinational from grid and the masks. Neighbour count 0..8 per cell; new = live ? survive_mask[n] : birth_mask[n].
- WRAP=1: row/column indices are taken mod ROWS/COLS. WRAP=0: missing neighbours count as 0.
- "Evolve" means the following on the same edge: grid<=next_grid; generation<=generation+1, saturating at 2^GEN_W-1; extinct<=(next_grid==0); stable<=(next_grid==grid).
- Latency: one clock from an enabling input to the updated grid.
- FSM states: IDLE, RUN, HALT.
- IDLE:
  - load: grid<=seed, generation<=0, flags<=0.
  - Otherwise, run=1 -> RUN, with no evolve on the transition edge.
  - Otherwise, step=1 -> one evolve, remain IDLE.
- RUN:
  - load: reload as above, stay RUN.
  - Otherwise, run=0 -> IDLE with no evolve.
  - Otherwise, stop_on_stable=1 and next_grid==grid -> stable<=1, -> HALT. Grid and generation are not updated.
  - Otherwise, evolve.
- HALT: grid and generation are held; halted=1; step is ignored.
  - load: reload -> IDLE.
  - Otherwise, run=0 -> IDLE.
- Priority: load > run > step. step while run=1 is ignored.
- An extinct grid keeps evolving in RUN; it is stable, so it halts if stop_on_stable=1.
- reset asserted mid-operation aborts immediately to the reset values; no partial update.

Decomposition:
- Package life_pkg:
  - state_t enum {IDLE, RUN, HALT}.
  - CONWAY_BIRTH = 9'h008 and CONWAY_SURVIVE = 9'h00C constants.
  - Function idx(r,c,COLS).
- Sub-module life_cell: 8 neighbour bits + self + masks -> next bit, using a popcount and a mask lookup. Instantiated ROWS*COLS times from a generate loop; wrap/edge selection is done in the generate.

Test Plan:
- Blinker, 8x8, Conway masks: load seed=64'h0000_0000_1C00_0000, one step -> grid=64'h0000_0008_0808_0000, generation=1. Second step -> grid returns to seed, generation=2.
- Block still life: seed=64'h0000_0000_0000_0303, run=1, stop_on_stable=1 -> halted=1 and stable=1 within 2 cycles, generation=0, grid unchanged.
- Extinction: seed=64'h1, step -> grid=0, extinct=1, generation=1.
- Wrap mode: seed=64'h8100_0000_0000_0081 (corners). WRAP=1: one step leaves grid unchanged, stable=1. WRAP=0: one step gives grid=0, extinct=1.
- Load mid-run: run=1 for 5 cycles, pulse load with new seed -> next cycle grid=seed, generation=0, state stays RUN. Separately, reset low mid-run -> all outputs 0 asynchronously.
- GEN_W=4, 4x4 toroidal blinker, run 20 cycles -> generation saturates at 15, grid keeps oscillating.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life engine.
package life_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [8:0] CONWAY_BIRTH   = 9'h008;
  localparam logic [8:0] CONWAY_SURVIVE = 9'h00C;

  // Flat bit position of cell (r,c) in a grid with `cols` columns.
  function automatic int idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_cell.sv
// One Game-of-Life cell: counts live neighbours and looks the count up in
// the birth or survive mask depending on its own state.
module life_cell (
  input  logic [7:0] nbr_i,
  input  logic       self_i,
  input  logic [8:0] birth_mask_i,
  input  logic [8:0] survive_mask_i,
  output logic       next_o
);

  logic [3:0] count;

  always_comb begin
    count = '0;
    for (int k = 0; k < 8; k++) begin
      count = count + {3'b000, nbr_i[k]};
    end
  end

  assign next_o = self_i ? survive_mask_i[count] : birth_mask_i[count];

endmodule

// File: rtl/life_engine.sv
// Parametrised Game-of-Life grid with run/step/halt control, programmable
// rules, toroidal or dead-edge boundaries and stable/extinct detection.
module life_engine import life_pkg::*; #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 run,
  input  logic                 step,
  input  logic                 stop_on_stable,
  input  logic [8:0]           birth_mask,
  input  logic [8:0]           survive_mask,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     generation,
  output logic                 stable,
  output logic                 extinct,
  output logic                 halted
);

  localparam int N = ROWS * COLS;

  state_t           state_q, state_d;
  logic [N-1:0]     grid_q, grid_d, next_grid;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             stable_q, stable_d;
  logic             extinct_q, extinct_d;
  logic             do_load, do_evolve, is_stable;

  // Neighbour k (0..8, row-major over the 3x3 window, 4 = self) maps to nbr bit.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      logic [7:0] nbr;
      for (genvar gk = 0; gk < 9; gk++) begin : g_nbr
        if (gk != 4) begin : g_live
          localparam int RR  = gi + gk / 3 - 1;
          localparam int CC  = gj + gk % 3 - 1;
          localparam int BIT = (gk < 4) ? gk : gk - 1;
          if (WRAP != 0) begin : g_wrap
            assign nbr[BIT] = grid_q[idx((RR + ROWS) % ROWS, (CC + COLS) % COLS, COLS)];
          end else if (RR >= 0 && RR < ROWS && CC >= 0 && CC < COLS) begin : g_in
            assign nbr[BIT] = grid_q[idx(RR, CC, COLS)];
          end else begin : g_edge
            assign nbr[BIT] = 1'b0;
          end
        end
      end
      life_cell u_cell (
        .nbr_i          (nbr),
        .self_i         (grid_q[idx(gi, gj, COLS)]),
        .birth_mask_i   (birth_mask),
        .survive_mask_i (survive_mask),
        .next_o         (next_grid[idx(gi, gj, COLS)])
      );
    end
  end

  assign is_stable = (next_grid == grid_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    gen_d     = gen_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
    do_load   = 1'b0;
    do_evolve = 1'b0;
    case (state_q)
      IDLE: begin
        if (load)      do_load = 1'b1;
        else if (run)  state_d = RUN;
        else if (step) do_evolve = 1'b1;
      end
      RUN: begin
        if (load)      do_load = 1'b1;
        else if (!run) state_d = IDLE;
        else if (stop_on_stable && is_stable) begin
          stable_d = 1'b1;
          state_d  = HALT;
        end else       do_evolve = 1'b1;
      end
      HALT: begin
        if (load) begin
          do_load = 1'b1;
          state_d = IDLE;
        end else if (!run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (do_load) begin
      grid_d    = seed;
      gen_d     = '0;
      stable_d  = 1'b0;
      extinct_d = 1'b0;
    end
    if (do_evolve) begin
      grid_d    = next_grid;
      gen_d     = (&gen_q) ? gen_q : gen_q + GEN_W'(1);
      extinct_d = (next_grid == '0);
      stable_d  = is_stable;
    end
  end

  always_comb begin
    grid       = grid_q;
    generation = gen_q;
    stable     = stable_q;
    extinct    = extinct_q;
    halted     = (state_q == HALT);
  end

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench for life_engine: three instances (8x8 toroidal, 8x8
// dead-edge, 4x4 toroidal with 4-bit counter) checked against a cell-array model.
module tb_life_engine;
  import life_pkg::*;

  localparam int MODE_IDLE = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_HALT = 2;

  typedef struct packed {
    logic [63:0] grid;
    logic [15:0] gen;
    logic        st;
    logic        ex;
    logic        hl;
  } snap_t;

  typedef struct packed {
    snap_t [2:0] s;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load, run, step, sos;
  logic [63:0] seed;
  logic [8:0]  bm, sm;
  logic [8:0]  want_b, want_s;

  logic [63:0] g0, g1;
  logic [15:0] g2;
  logic [15:0] gen0, gen1;
  logic [3:0]  gen2;
  logic        st0, st1, st2, ex0, ex1, ex2, hl0, hl1, hl2;

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  exp_t sbq[$];

  int          R   [3] = '{8, 8, 4};
  int          C   [3] = '{8, 8, 4};
  bit          WR  [3] = '{1'b1, 1'b0, 1'b1};
  int          GMAX[3] = '{65535, 65535, 15};
  logic [63:0] m_grid[3];
  int          m_gen [3];
  bit          m_st  [3];
  bit          m_ex  [3];
  int          m_mode[3];

  always #5 clk = ~clk;

  life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16)) dut0 (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
    .stop_on_stable(sos), .birth_mask(bm), .survive_mask(sm),
    .grid(g0), .generation(gen0), .stable(st0), .extinct(ex0), .halted(hl0));

  life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(16)) dut1 (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
    .stop_on_stable(sos), .birth_mask(bm), .survive_mask(sm),
    .grid(g1), .generation(gen1), .stable(st1), .extinct(ex1), .halted(hl1));

  life_engine #(.ROWS(4), .COLS(4), .WRAP(1), .GEN_W(4)) dut2 (
    .clk(clk), .reset(reset), .load(load), .seed(seed[15:0]), .run(run), .step(step),
    .stop_on_stable(sos), .birth_mask(bm), .survive_mask(sm),
    .grid(g2), .generation(gen2), .stable(st2), .extinct(ex2), .halted(hl2));

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h required=%h", name, d, act, exp_v);
    end
  endtask

  // Reference: count neighbours cell by cell on a 2-D view of the flat grid.
  function automatic logic [63:0] life_next(input logic [63:0] g, input int rows, input int cols,
                                            input bit wrap, input logic [8:0] b, input logic [8:0] s);
    logic [63:0] res;
    res = '0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (wrap) begin
              rr = (rr + rows) % rows;
              cc = (cc + cols) % cols;
            end else if (rr < 0 || rr >= rows || cc < 0 || cc >= cols) continue;
            if (g[rr*cols+cc]) n++;
          end
        end
        res[r*cols+c] = g[r*cols+c] ? s[n] : b[n];
      end
    end
    return res;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_grid[d] = '0; m_gen[d] = 0; m_st[d] = 1'b0; m_ex[d] = 1'b0; m_mode[d] = MODE_IDLE;
    end
  endtask

  task automatic model_step(input int d, input bit ld, input logic [63:0] sd, input bit rn,
                            input bit stp, input bit so);
    logic [63:0] nx, msk;
    bit          ev, rl;
    msk = (R[d] * C[d] == 64) ? '1 : ((64'd1 << (R[d] * C[d])) - 64'd1);
    nx  = life_next(m_grid[d], R[d], C[d], WR[d], bm, sm);
    ev  = 1'b0;
    rl  = 1'b0;
    if (m_mode[d] == MODE_IDLE) begin
      if (ld) rl = 1'b1;
      else if (rn) m_mode[d] = MODE_RUN;
      else if (stp) ev = 1'b1;
    end else if (m_mode[d] == MODE_RUN) begin
      if (ld) rl = 1'b1;
      else if (!rn) m_mode[d] = MODE_IDLE;
      else if (so && nx == m_grid[d]) begin
        m_st[d] = 1'b1;
        m_mode[d] = MODE_HALT;
      end else ev = 1'b1;
    end else begin
      if (ld) begin
        rl = 1'b1;
        m_mode[d] = MODE_IDLE;
      end else if (!rn) m_mode[d] = MODE_IDLE;
    end
    if (rl) begin
      m_grid[d] = sd & msk; m_gen[d] = 0; m_st[d] = 1'b0; m_ex[d] = 1'b0;
    end
    if (ev) begin
      m_st[d]   = (nx == m_grid[d]);
      m_ex[d]   = (nx == 64'd0);
      m_grid[d] = nx;
      if (m_gen[d] < GMAX[d]) m_gen[d]++;
    end
  endtask

  task automatic drive(input bit ld, input logic [63:0] sd, input bit rn, input bit stp, input bit so);
    exp_t e;
    @(negedge clk);
    load = ld; seed = sd; run = rn; step = stp; sos = so; bm = want_b; sm = want_s;
    for (int d = 0; d < 3; d++) begin
      model_step(d, ld, sd, rn, stp, so);
      e.s[d].grid = m_grid[d];
      e.s[d].gen  = 16'(m_gen[d]);
      e.s[d].st   = m_st[d];
      e.s[d].ex   = m_ex[d];
      e.s[d].hl   = (m_mode[d] == MODE_HALT);
    end
    sbq.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic cmp_dut(input int d, input snap_t e, input logic [63:0] g, input logic [15:0] gn,
                         input logic s, input logic x, input logic h);
    chk("grid", d, g, e.grid);
    chk("generation", d, 64'(gn), 64'(e.gen));
    chk("stable", d, 64'(s), 64'(e.st));
    chk("extinct", d, 64'(x), 64'(e.ex));
    chk("halted", d, 64'(h), 64'(e.hl));
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 0, g0 | 64'(gen0) | 64'({st0, ex0, hl0}), 64'd0);
    chk(name, 1, g1 | 64'(gen1) | 64'({st1, ex1, hl1}), 64'd0);
    chk(name, 2, 64'(g2) | 64'(gen2) | 64'({st2, ex2, hl2}), 64'd0);
  endtask

  // Monitor: every clock the DUTs present a new state; pop and compare.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        txn++;
        cmp_dut(0, e.s[0], g0, gen0, st0, ex0, hl0);
        cmp_dut(1, e.s[1], g1, gen1, st1, ex1, hl1);
        cmp_dut(2, e.s[2], {48'd0, g2}, {12'd0, gen2}, st2, ex2, hl2);
        $display("txn %0d: grid0=%h gen0=%0d gen1=%0d gen2=%0d halted=%b%b%b",
                 txn, g0, gen0, gen1, gen2, hl0, hl1, hl2);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bit run_lvl;
    logic [63:0] sd;
    reset = 1'b1; load = 1'b0; run = 1'b0; step = 1'b0; sos = 1'b0; seed = '0;
    want_b = CONWAY_BIRTH; want_s = CONWAY_SURVIVE; bm = want_b; sm = want_s;
    model_reset();
    #2 reset = 1'b0;
    #1 chk_all_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Blinker oscillates with period 2.
    drive(1'b1, 64'h0000_0000_1C00_0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("blinker_step1_grid", 0, g0, 64'h0000_0008_0808_0000);
    chk("blinker_step1_gen", 0, 64'(gen0), 64'd1);
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("blinker_step2_grid", 0, g0, 64'h0000_0000_1C00_0000);
    chk("blinker_step2_gen", 0, 64'(gen0), 64'd2);

    // Block still life halts without advancing; step ignored in HALT.
    drive(1'b1, 64'h0000_0000_0000_0303, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("block_halted", 0, 64'(hl0), 64'd1);
    chk("block_stable", 0, 64'(st0), 64'd1);
    chk("block_gen", 0, 64'(gen0), 64'd0);
    chk("block_grid", 0, g0, 64'h0000_0000_0000_0303);
    drive(1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Lone cell dies.
    drive(1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("extinct_grid", 0, g0, 64'd0);
    chk("extinct_flag", 0, 64'(ex0), 64'd1);
    chk("extinct_gen", 0, 64'(gen0), 64'd1);

    // Corners form a block only through the wrapped edges.
    drive(1'b1, 64'h8100_0000_0000_0081, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("corner_wrap_grid", 0, g0, 64'h8100_0000_0000_0081);
    chk("corner_wrap_stable", 0, 64'(st0), 64'd1);
    chk("corner_edge_grid", 1, g1, 64'd0);
    chk("corner_edge_extinct", 1, 64'(ex1), 64'd1);

    // Load while running reloads and stays in RUN.
    drive(1'b1, 64'h0000_0000_0007_0000, 1'b0, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h0000_0020_1070_0000, 1'b1, 1'b0, 1'b0);
    settle();
    chk("midload_grid", 0, g0, 64'h0000_0020_1070_0000);
    chk("midload_gen", 0, 64'(gen0), 64'd0);
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("midload_still_run", 0, 64'(gen0), 64'd1);

    // Asynchronous reset in the middle of a clock phase.
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    settle();
    #1 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    load = 1'b0; run = 1'b0; step = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Counter saturation on the 4-bit instance, toroidal 4x4 blinker.
    drive(1'b1, 64'h0000_0000_0000_0070, 1'b0, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("sat_gen", 2, 64'(gen2), 64'd15);
    chk("sat_grid", 2, 64'(g2), 64'h0222);
    chk("sat_wide_gen", 0, 64'(gen0), 64'd19);
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Randomised traffic.
    run_lvl = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          want_b = 9'($urandom);
          want_s = 9'($urandom);
        end else begin
          want_b = CONWAY_BIRTH;
          want_s = CONWAY_SURVIVE;
        end
      end
      if ($urandom_range(0, 9) == 0) run_lvl = ~run_lvl;
      sd = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) sd = sd & {$urandom, $urandom};
      drive($urandom_range(0, 15) == 0, sd, run_lvl,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    for (int k = 0; k < 10 && sbq.size() > 0; k++) settle();
    chk("scoreboard_drained", 0, 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
